// File: rtl/sbs_window_counter_if.sv
// Result handshake between the window counter and its consumer.
// Producer drives valid/value; consumer drives ready.
interface sbs_window_counter_if #(
  parameter int LOGLEN = 8
) ();
  logic              out_valid;
  logic              out_ready;
  logic [LOGLEN:0]   out_value;

  modport master (
    output out_valid,
    output out_value,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_value,
    output out_ready
  );
endinterface

// File: rtl/sbs_window_counter.sv
// Counts ones of a stochastic bitstream over a 2^LOGLEN window,
// after discarding WARMUP settle cycles; result via valid/ready.
module sbs_window_counter #(
  parameter int LOGLEN = 8,
  parameter int WARMUP = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clr,
  input  logic in_bit,
  output logic busy,
  sbs_window_counter_if.master res
);

  localparam int W = LOGLEN + 1;
  localparam bit HAS_WARM = (WARMUP > 0);
  localparam logic [15:0] WARM_LAST =
    16'(HAS_WARM ? WARMUP - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    WARM,
    COUNT,
    DONE
  } state_t;

  state_t            state;
  logic [15:0]       warm_cnt;
  logic [LOGLEN-1:0] win_cnt;
  logic [W-1:0]      value;
  logic              valid;
  logic              go;

  // A finished result may only be replaced once it has been consumed.
  assign go = start &
    ((state == IDLE) |
     ((state == DONE) & res.out_ready));

  assign res.out_value = value;
  assign res.out_valid = valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      valid    <= 1'b0;
      value    <= '0;
      warm_cnt <= '0;
      win_cnt  <= '0;
    end else if (clr) begin
      state    <= IDLE;
      busy     <= 1'b0;
      valid    <= 1'b0;
      value    <= '0;
      warm_cnt <= '0;
      win_cnt  <= '0;
    end else if (go) begin
      state    <= HAS_WARM ? WARM : COUNT;
      busy     <= 1'b1;
      valid    <= 1'b0;
      value    <= '0;
      warm_cnt <= '0;
      win_cnt  <= '0;
    end else begin
      unique case (state)
        WARM: begin
          warm_cnt <= warm_cnt + 16'd1;
          if (warm_cnt == WARM_LAST)
            state <= COUNT;
        end
        COUNT: begin
          value   <= value + W'(in_bit);
          win_cnt <= win_cnt + 1'b1;
          // Window counter wraps to 0 on the last sample.
          if (&win_cnt) begin
            state <= DONE;
            busy  <= 1'b0;
            valid <= 1'b1;
          end
        end
        DONE: begin
          if (res.out_ready) begin
            state <= IDLE;
            valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sbs_window_counter.sv
// Randomized bench for sbs_window_counter against a window-sum model.
// Second instance covers the zero-warmup build.
module tb_sbs_window_counter;

  localparam int L  = 4;
  localparam int WU = 2;
  localparam int N  = 1 << L;
  localparam int SL = WU + N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic clr = 1'b0;
  logic in_bit = 1'b0;
  logic busy;
  logic start1 = 1'b0;
  logic in_bit1 = 1'b0;
  logic busy1;

  sbs_window_counter_if #(.LOGLEN(L)) r0 ();
  sbs_window_counter_if #(.LOGLEN(L)) r1 ();

  sbs_window_counter #(.LOGLEN(L), .WARMUP(WU)) u0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .clr    (clr),
    .in_bit (in_bit),
    .busy   (busy),
    .res    (r0)
  );

  sbs_window_counter #(.LOGLEN(L), .WARMUP(0)) u1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start1),
    .clr    (1'b0),
    .in_bit (in_bit1),
    .busy   (busy1),
    .res    (r1)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;
  bit seq [SL];
  bit seq1 [N];

  task automatic check(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected result: ones among the samples after the warmup prefix.
  function automatic int model();
    int s = 0;
    for (int k = WU; k < SL; k++) s += int'(seq[k]);
    return s;
  endfunction

  task automatic fill(input int mode);
    for (int k = 0; k < SL; k++) begin
      case (mode)
        0: seq[k] = 1'b1;
        1: seq[k] = 1'b0;
        2: seq[k] = (k < WU) ? 1'($urandom) : ((k - WU) % 2 == 0);
        3: seq[k] = (k < WU);
        default: seq[k] = 1'($urandom);
      endcase
    end
  endtask

  // Starts from IDLE or DONE (handshake in the start cycle); leaves DONE held.
  task automatic run(input string tag);
    start = 1'b1;
    r0.out_ready = 1'b1;
    in_bit = 1'($urandom);
    tick();
    start = 1'b0;
    r0.out_ready = 1'b0;
    check({tag, ".busy_on"}, int'(busy), 1);
    check({tag, ".valid_off"}, int'(r0.out_valid), 0);
    for (int k = 0; k < SL; k++) begin
      in_bit = seq[k];
      tick();
      if (k == SL - 2)
        check({tag, ".early"}, int'(r0.out_valid), 0);
    end
    in_bit = 1'($urandom);
    check({tag, ".valid"}, int'(r0.out_valid), 1);
    check({tag, ".busy_off"}, int'(busy), 0);
    check({tag, ".value"}, int'(r0.out_value), model());
  endtask

  // Starts a run and stops right before the edge taking sample 7.
  task automatic partial;
    start = 1'b1;
    r0.out_ready = 1'b1;
    tick();
    start = 1'b0;
    r0.out_ready = 1'b0;
    for (int k = 0; k < WU + 6; k++) begin
      in_bit = 1'b1;
      tick();
    end
  endtask

  initial begin
    int v;
    int e1;
    r0.out_ready = 1'b0;
    r1.out_ready = 1'b1;
    #2;
    check("rst.busy", int'(busy), 0);
    check("rst.valid", int'(r0.out_valid), 0);
    check("rst.value", int'(r0.out_value), 0);
    #5 rst_n = 1'b1;
    tick();
    check("idle.busy", int'(busy), 0);

    fill(0); run("ones");
    fill(1); run("zeros");
    fill(2); run("alt");
    fill(3); run("warm_only");
    for (int i = 0; i < 6; i++) begin
      fill(4);
      run($sformatf("rand%0d", i));
    end

    // Backpressure: start without ready must not disturb the result.
    v = int'(r0.out_value);
    for (int i = 0; i < 10; i++) begin
      start = 1'(i % 2);
      in_bit = 1'($urandom);
      tick();
      check("bp.valid", int'(r0.out_valid), 1);
      check("bp.value", int'(r0.out_value), v);
      check("bp.busy", int'(busy), 0);
    end
    start = 1'b0;
    r0.out_ready = 1'b1;
    tick();
    r0.out_ready = 1'b0;
    check("hs.valid", int'(r0.out_valid), 0);
    check("hs.hold", int'(r0.out_value), v);
    check("hs.busy", int'(busy), 0);

    // Abort by clr at sample 7.
    partial();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr.busy", int'(busy), 0);
    check("clr.valid", int'(r0.out_valid), 0);
    check("clr.value", int'(r0.out_value), 0);
    fill(0); run("after_clr");

    // clr beats start and handshake in DONE.
    clr = 1'b1;
    start = 1'b1;
    r0.out_ready = 1'b1;
    tick();
    clr = 1'b0;
    start = 1'b0;
    r0.out_ready = 1'b0;
    check("clrpri.busy", int'(busy), 0);
    check("clrpri.valid", int'(r0.out_valid), 0);
    check("clrpri.value", int'(r0.out_value), 0);

    // Abort by asynchronous reset at sample 7.
    partial();
    rst_n = 1'b0;
    #1;
    check("arst.busy", int'(busy), 0);
    check("arst.valid", int'(r0.out_valid), 0);
    check("arst.value", int'(r0.out_value), 0);
    tick();
    rst_n = 1'b1;
    tick();
    fill(0); run("after_rst");
    fill(4); run("rand_last");

    // Zero-warmup build: warm-phase ones are now counted.
    e1 = 0;
    for (int k = 0; k < N; k++) begin
      seq1[k] = (k < 2);
      e1 += int'(seq1[k]);
    end
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("w0.busy", int'(busy1), 1);
    for (int k = 0; k < N; k++) begin
      in_bit1 = seq1[k];
      tick();
      if (k == N - 2)
        check("w0.early", int'(r1.out_valid), 0);
    end
    check("w0.valid", int'(r1.out_valid), 1);
    check("w0.value", int'(r1.out_value), e1);
    tick();
    check("w0.consumed", int'(r1.out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
